clock_set_ctrl: RTL
===================

// Module: clock_set_ctrl
// PURPOSE
//  Time-setting controller for the BCD clockwork core. Sequences a user edit of
//  hours/minutes/seconds from debounced pulse buttons, drives the core's time_in bus
//  and active-low overwrite (time_ow), and freezes the core while editing.
//  Runs on the system clock; the core's clk_1hz is derived from clk, so time_cur is
//  treated as synchronous to clk.
// PARAMETERS
//  TIMEOUT_CYCLES  500_000_000  idle cycles in an edit state before auto-commit
//  BLINK_CYCLES    12_500_000   half-period of blink output, in clk cycles
//  CNT_W           29           width of timeout/blink counters (>= clog2 of both)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  mode_btn   in   1   1-cycle pulse: enter edit / advance field
//  inc_btn    in   1   1-cycle pulse: increment selected field
//  dec_btn    in   1   1-cycle pulse: decrement selected field
//  time_cur   in   20  live core time {hh[5:0],mm[6:0],ss[6:0]}, BCD
//  time_in    out  20  edit value to core, same format
//  time_ow    out  1   core overwrite, active low; low for the whole edit
//  field_sel  out  2   0=none, 1=hours, 2=minutes, 3=seconds
//  blink      out  1   display blink for the selected field
// BEHAVIOUR
//  - Reset: state RUN, edit_reg=0, time_in=0, time_ow=1, field_sel=0, blink=0,
//    counters=0. Reset mid-edit: abandon the edit, release time_ow, keep the core's old time.
//  - All outputs registered. time_in = edit_reg. time_ow = 0 in every SET_* state.
//  - States: RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN, advanced by mode_btn.
//  - RUN + mode_btn: next edge edit_reg<=time_cur, state SET_HR, time_ow<=0. Core
//    loads time_in asynchronously and holds it.
//  - SET_SEC + mode_btn: state RUN, time_ow<=1. The core resumes from edit_reg at
//    its next clk_1hz edge.
//  - inc_btn in a SET_* state: selected field +1 in BCD. Units 9 -> tens+1, units 0.
//    Wrap: hours 23->00, min/sec 59->00.
//  - dec_btn: field -1 in BCD. Units 0 -> tens-1, units 9. Wrap: 00->23 (hours),
//    00->59 (min/sec).
//  - Unselected fields unchanged. Result is always valid BCD within range.
//  - Priority in one cycle: mode_btn beats inc/dec, whose presses are dropped.
//    inc_btn & dec_btn together: both ignored.
//  - Buttons in RUN other than mode_btn: ignored.
//  - Timeout: the counter clears on entry to a SET_* state and on any button pulse;
//    otherwise it increments. At TIMEOUT_CYCLES-1 -> RUN, time_ow<=1 (commit edit_reg).
//  - Blink: 0 in RUN. On SET_* entry, or on inc/dec, blink<=1 and the blink counter
//    clears. blink toggles every BLINK_CYCLES cycles.
//  - Edit latency: button pulse at edge N -> time_in updated after edge N+1.
// STRUCTURE
//  - Package clock_set_pkg:
//    - state enum RUN/SET_HR/SET_MIN/SET_SEC;
//    - field codes FLD_NONE/HR/MIN/SEC;
//    - HR_MAX=6'h23, MS_MAX=7'h59;
//    - widths HR_W=6, MS_W=7, TIME_W=20.
//  - Sub-module bcd_field_step (combinational): in value, max, inc, dec -> stepped
//    BCD value. Instantiated once, muxed by field_sel.
// TESTING
//  Benches override TIMEOUT_CYCLES=64, BLINK_CYCLES=4.
//  1 Enter/exit: time_cur=14:37:52, mode_btn. -> time_ow=0, time_in=14:37:52,
//    field_sel=1. Three more mode pulses -> time_ow=1, field_sel=0.
//  2 Wrap up: SET_HR at 23, inc -> 00. SET_MIN at 59, inc -> 00. SET_SEC at 09, inc -> 10.
//  3 Wrap down: SET_HR at 00, dec -> 23. SET_MIN at 40, dec -> 39.
//    SET_SEC at 00, dec -> 59.
//  4 Collisions: mode+inc in SET_MIN -> SET_SEC with minutes unchanged. inc+dec in SET_HR
//    -> no change. inc in RUN -> no change.
//  5 Timeout: enter SET_MIN, set 45, idle 64 cycles -> RUN, time_ow=1, time_in mm=45.
//    A press at cycle 60 restarts the count.
//  6 Reset mid-edit: in SET_SEC assert rst -> immediately time_ow=1, field_sel=0,
//    blink=0, time_in=0. After release the state is RUN.

Source files
------------

// File: rtl/clock_set_pkg.sv
`default_nettype none
// clock_set_pkg: shared types and constants for the clock time-setting controller.
// Rev 1.0
package clock_set_pkg;

  localparam int HR_W   = 6;
  localparam int MS_W   = 7;
  localparam int TIME_W = 20;

  localparam logic [HR_W-1:0] HR_MAX = 6'h23;
  localparam logic [MS_W-1:0] MS_MAX = 7'h59;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_t;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HR   = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;
  localparam logic [1:0] FLD_SEC  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/clock_set_ctrl_bcd_field_step.sv
`default_nettype none
// bcd_field_step: one BCD increment/decrement with wrap between 00 and max.
// Rev 1.0
module bcd_field_step (
  input  logic [6:0] value,
  input  logic [6:0] max,
  input  logic       inc,
  input  logic       dec,
  output logic [6:0] result
);

  always_comb begin
    result = value;
    if (inc && !dec) begin
      // Out-of-range input also wraps to 00 so the result is always legal
      if (value >= max)
        result = 7'h00;
      else if (value[3:0] >= 4'd9)
        result = {value[6:4] + 3'd1, 4'd0};
      else
        result = {value[6:4], value[3:0] + 4'd1};
    end else if (dec && !inc) begin
      if (value == 7'h00 || value > max)
        result = max;
      else if (value[3:0] == 4'd0)
        result = {value[6:4] - 3'd1, 4'd9};
      else
        result = {value[6:4], value[3:0] - 4'd1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// clock_set_ctrl: sequences a user edit of hh:mm:ss and overwrites the BCD clock core.
// Rev 1.0
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned BLINK_CYCLES   = 12_500_000,
  parameter int unsigned CNT_W          = 29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_btn,
  input  logic        inc_btn,
  input  logic        dec_btn,
  input  logic [19:0] time_cur,
  output logic [19:0] time_in,
  output logic        time_ow,
  output logic [1:0]  field_sel,
  output logic        blink
);

  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);

  state_t              state_q, state_d;
  logic [TIME_W-1:0]   edit_q, edit_d;
  logic                time_ow_q, time_ow_d;
  logic [1:0]          field_sel_q, field_sel_d;
  logic                blink_q, blink_d;
  logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]    blink_cnt_q, blink_cnt_d;

  logic [6:0] fld_val, fld_max, fld_next;
  logic       step_inc, step_dec, any_btn;
  logic       fld_next_unused;

  // mode_btn wins; simultaneous inc and dec cancel inside the stepper
  assign step_inc = inc_btn & ~mode_btn;
  assign step_dec = dec_btn & ~mode_btn;
  assign any_btn  = mode_btn | inc_btn | dec_btn;

  always_comb begin
    fld_val = edit_q[6:0];
    fld_max = MS_MAX;
    case (field_sel_q)
      FLD_HR: begin
        fld_val = {1'b0, edit_q[19:14]};
        fld_max = {1'b0, HR_MAX};
      end
      FLD_MIN: fld_val = edit_q[13:7];
      default: fld_val = edit_q[6:0];
    endcase
  end

  bcd_field_step u_step (
    .value  (fld_val),
    .max    (fld_max),
    .inc    (step_inc),
    .dec    (step_dec),
    .result (fld_next)
  );

  // Hours never exceed 23, so the top bit of the stepped value is always zero
  assign fld_next_unused = fld_next[6];

  always_comb begin
    state_d     = state_q;
    edit_d      = edit_q;
    time_ow_d   = time_ow_q;
    field_sel_d = field_sel_q;
    blink_d     = blink_q;
    tmo_cnt_d   = tmo_cnt_q;
    blink_cnt_d = blink_cnt_q;

    if (state_q == RUN) begin
      time_ow_d   = 1'b1;
      field_sel_d = FLD_NONE;
      blink_d     = 1'b0;
      tmo_cnt_d   = '0;
      blink_cnt_d = '0;
      if (mode_btn) begin
        edit_d      = time_cur;
        state_d     = SET_HR;
        time_ow_d   = 1'b0;
        field_sel_d = FLD_HR;
        blink_d     = 1'b1;
      end
    end else if (mode_btn) begin
      tmo_cnt_d   = '0;
      blink_cnt_d = '0;
      if (state_q == SET_SEC) begin
        state_d     = RUN;
        time_ow_d   = 1'b1;
        field_sel_d = FLD_NONE;
        blink_d     = 1'b0;
      end else begin
        state_d     = (state_q == SET_HR) ? SET_MIN : SET_SEC;
        field_sel_d = (state_q == SET_HR) ? FLD_MIN : FLD_SEC;
        blink_d     = 1'b1;
      end
    end else if (any_btn) begin
      tmo_cnt_d = '0;
      if (inc_btn ^ dec_btn) begin
        blink_d     = 1'b1;
        blink_cnt_d = '0;
        case (field_sel_q)
          FLD_HR:  edit_d[19:14] = fld_next[5:0];
          FLD_MIN: edit_d[13:7]  = fld_next;
          default: edit_d[6:0]   = fld_next;
        endcase
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_d     = ~blink_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end else if (tmo_cnt_q == TMO_LAST) begin
      // Idle too long: commit whatever has been edited so far
      state_d     = RUN;
      time_ow_d   = 1'b1;
      field_sel_d = FLD_NONE;
      blink_d     = 1'b0;
      tmo_cnt_d   = '0;
      blink_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_d     = ~blink_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      edit_q      <= '0;
      time_ow_q   <= 1'b1;
      field_sel_q <= FLD_NONE;
      blink_q     <= 1'b0;
      tmo_cnt_q   <= '0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      edit_q      <= edit_d;
      time_ow_q   <= time_ow_d;
      field_sel_q <= field_sel_d;
      blink_q     <= blink_d;
      tmo_cnt_q   <= tmo_cnt_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign time_in   = edit_q;
  assign time_ow   = time_ow_q;
  assign field_sel = field_sel_q;
  assign blink     = blink_q;

endmodule
`default_nettype wire
